// File: rtl/vga_timing_gen.sv
// vga_timing_gen: parametrised VGA timing and test-pattern/pixel generator.
//   clk, reset         : clock and synchronous active-high reset
//   pix_en             : pixel-clock enable; counters and outputs advance only when high
//   mode               : 0 black, 1 colour bars, 2 checkerboard, 3 external pixel
//   ext_r/ext_g/ext_b  : external pixel for the current (pix_x, pix_y)
//   pix_x, pix_y       : current horizontal/vertical counters (zero latency)
//   r/g/b, hs, vs, de  : registered colour, syncs and data enable (one enabled-pixel latency)
//   frame_start        : one-clk pulse aligned with the first visible pixel of a frame
module vga_timing_gen #(
  parameter int unsigned H_ACTIVE   = 640,
  parameter int unsigned H_FP       = 16,
  parameter int unsigned H_SYNC     = 96,
  parameter int unsigned H_BP       = 48,
  parameter int unsigned V_ACTIVE   = 480,
  parameter int unsigned V_FP       = 10,
  parameter int unsigned V_SYNC     = 2,
  parameter int unsigned V_BP       = 33,
  parameter bit          HS_POL     = 1'b0,
  parameter bit          VS_POL     = 1'b0,
  parameter int unsigned COLOR_W    = 4,
  parameter int unsigned CHECK_LOG2 = 5,
  localparam int unsigned H_TOTAL   = H_ACTIVE + H_FP + H_SYNC + H_BP,
  localparam int unsigned V_TOTAL   = V_ACTIVE + V_FP + V_SYNC + V_BP,
  localparam int unsigned HW        = $clog2(H_TOTAL),
  localparam int unsigned VW        = $clog2(V_TOTAL)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               pix_en,
  input  logic [1:0]         mode,
  input  logic [COLOR_W-1:0] ext_r,
  input  logic [COLOR_W-1:0] ext_g,
  input  logic [COLOR_W-1:0] ext_b,
  output logic [HW-1:0]      pix_x,
  output logic [VW-1:0]      pix_y,
  output logic [COLOR_W-1:0] r,
  output logic [COLOR_W-1:0] g,
  output logic [COLOR_W-1:0] b,
  output logic               hs,
  output logic               vs,
  output logic               de,
  output logic               frame_start
);

  localparam logic [1:0] ModeBlack = 2'd0;
  localparam logic [1:0] ModeBars  = 2'd1;
  localparam logic [1:0] ModeCheck = 2'd2;
  localparam logic [1:0] ModeExt   = 2'd3;

  localparam logic [HW-1:0] HLast     = HW'(H_TOTAL - 1);
  localparam logic [HW-1:0] HActEnd   = HW'(H_ACTIVE);
  localparam logic [HW-1:0] HSyncBeg  = HW'(H_ACTIVE + H_FP);
  localparam logic [HW-1:0] HSyncEnd  = HW'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [HW-1:0] BarW      = HW'(H_ACTIVE / 8);
  localparam logic [VW-1:0] VLast     = VW'(V_TOTAL - 1);
  localparam logic [VW-1:0] VActEnd   = VW'(V_ACTIVE);
  localparam logic [VW-1:0] VSyncBeg  = VW'(V_ACTIVE + V_FP);
  localparam logic [VW-1:0] VSyncEnd  = VW'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic [COLOR_W-1:0] Full = {COLOR_W{1'b1}};

  logic [HW-1:0]      h_q, h_d;
  logic [VW-1:0]      v_q, v_d;
  logic [1:0]         mode_q, mode_d;
  logic [COLOR_W-1:0] r_q, r_d, g_q, g_d, b_q, b_d;
  logic               hs_q, hs_d, vs_q, vs_d, de_q, de_d, fs_q, fs_d;

  logic       frame_first, active, in_hsync, in_vsync, chk_bit;
  logic [1:0] mode_eff;
  logic [2:0] bar_idx;

  always_comb begin
    frame_first = (h_q == '0) && (v_q == '0);
    active      = (h_q < HActEnd) && (v_q < VActEnd);
    in_hsync    = (h_q >= HSyncBeg) && (h_q < HSyncEnd);
    in_vsync    = (v_q >= VSyncBeg) && (v_q < VSyncEnd);
    // The pixel at (0,0) already uses the mode being latched this cycle.
    mode_eff    = frame_first ? mode : mode_q;
    bar_idx     = 3'(h_q / BarW);
    chk_bit     = |((h_q >> CHECK_LOG2) & HW'(1)) ^ |((v_q >> CHECK_LOG2) & VW'(1));

    h_d    = h_q;
    v_d    = v_q;
    mode_d = mode_q;
    r_d    = r_q;
    g_d    = g_q;
    b_d    = b_q;
    hs_d   = hs_q;
    vs_d   = vs_q;
    de_d   = de_q;
    fs_d   = 1'b0;  // pulse lasts a single clk even when pix_en stays low

    if (pix_en) begin
      h_d = (h_q == HLast) ? '0 : h_q + 1'b1;
      if (h_q == HLast) begin
        v_d = (v_q == VLast) ? '0 : v_q + 1'b1;
      end
      if (frame_first) begin
        mode_d = mode;
      end
      hs_d = in_hsync ? HS_POL : ~HS_POL;
      vs_d = in_vsync ? VS_POL : ~VS_POL;
      de_d = active;
      fs_d = frame_first;
      r_d  = '0;
      g_d  = '0;
      b_d  = '0;
      if (active) begin
        unique case (mode_eff)
          ModeBlack: ;
          ModeBars: begin
            r_d = bar_idx[1] ? '0 : Full;
            g_d = bar_idx[2] ? '0 : Full;
            b_d = bar_idx[0] ? '0 : Full;
          end
          ModeCheck: begin
            r_d = chk_bit ? '0 : Full;
            g_d = chk_bit ? '0 : Full;
            b_d = chk_bit ? '0 : Full;
          end
          ModeExt: begin
            r_d = ext_r;
            g_d = ext_g;
            b_d = ext_b;
          end
          default: ;
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      h_q    <= '0;
      v_q    <= '0;
      mode_q <= ModeBlack;
      r_q    <= '0;
      g_q    <= '0;
      b_q    <= '0;
      hs_q   <= ~HS_POL;
      vs_q   <= ~VS_POL;
      de_q   <= 1'b0;
      fs_q   <= 1'b0;
    end else begin
      h_q    <= h_d;
      v_q    <= v_d;
      mode_q <= mode_d;
      r_q    <= r_d;
      g_q    <= g_d;
      b_q    <= b_d;
      hs_q   <= hs_d;
      vs_q   <= vs_d;
      de_q   <= de_d;
      fs_q   <= fs_d;
    end
  end

  assign pix_x       = h_q;
  assign pix_y       = v_q;
  assign r           = r_q;
  assign g           = g_q;
  assign b           = b_q;
  assign hs          = hs_q;
  assign vs          = vs_q;
  assign de          = de_q;
  assign frame_start = fs_q;

endmodule
